// File: rtl/spie_arb_pkg.sv
// ============================================================================
// Module   : spie_arb_pkg
// Contents : shared state encodings, field constants and sizing helper for spie_arb
// Revision : 1.0
// ============================================================================
`default_nettype none

package spie_arb_pkg;

   localparam int   DATA_W    = 32;
   localparam logic CTRL_ADDR = 1'b1;
   localparam int   CS_HI     = 2;
   localparam int   CS_LO     = 0;

`ifdef SPIE_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FORCE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;
`endif

   function automatic int clog2_min1(input int v);
      return (v > 2) ? $clog2(v) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spie_arb_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Contents : combinational round-robin picker, first request at or after ptr
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import spie_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int OW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [OW-1:0] ptr,
   output logic          valid,
   output logic [OW-1:0] idx
);

   function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return OW'(s);
   endfunction

   // Scan from the far end so the last hit is the one closest to ptr.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[wrap_idx(ptr, k)]) begin
            valid = 1'b1;
            idx   = wrap_idx(ptr, k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spie_arb.sv
// ============================================================================
// Module   : spie_arb
// Contents : round-robin arbiter / lock manager sharing one spie device.
//            Optional forced lock release compiled in with SPIE_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spie_arb
   import spie_arb_pkg::*;
#(
   parameter int num_req        = 4,
   parameter int timeout_cycles = 100000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [num_req-1:0]            req_stb,
   input  logic [num_req-1:0]            req_we,
   input  logic [num_req-1:0]            req_addr,
   input  logic [DATA_W*num_req-1:0]     req_data_in,
   output logic [DATA_W-1:0]             req_data_out,
   output logic [num_req-1:0]            req_ack,
   output logic                          dev_stb,
   output logic                          dev_we,
   output logic                          dev_addr,
   output logic [DATA_W-1:0]             dev_data_out,
   input  logic [DATA_W-1:0]             dev_data_in,
   input  logic                          dev_ack,
   output logic                          locked,
   output logic [clog2_min1(num_req)-1:0] owner,
   output logic                          timeout_evt
);

   localparam int OW = clog2_min1(num_req);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [OW-1:0]     r_gnt;
   logic [OW-1:0]     r_ptr;
   logic [OW-1:0]     w_gnt_nxt;
   logic [OW-1:0]     w_ptr_nxt;
   logic [OW-1:0]     w_ptr_inc;
   logic              w_pick_valid;
   logic [OW-1:0]     w_pick_idx;
   logic              w_own_stb;
   logic              w_own_we;
   logic              w_own_addr;
   logic [DATA_W-1:0] w_own_data;
   logic              w_lock_wr;
   logic              w_rel_wr;

   rr_pick #(.N(num_req), .OW(OW)) u_pick (
      .req   (req_stb),
      .ptr   (r_ptr),
      .valid (w_pick_valid),
      .idx   (w_pick_idx)
   );

   assign w_own_stb  = req_stb[r_gnt];
   assign w_own_we   = req_we[r_gnt];
   assign w_own_addr = req_addr[r_gnt];
   assign w_own_data = req_data_in[r_gnt*DATA_W +: DATA_W];
   assign w_lock_wr  = w_own_stb & w_own_we & (w_own_addr == CTRL_ADDR) & (w_own_data[CS_HI:CS_LO] != '0);
   assign w_rel_wr   = w_own_stb & w_own_we & (w_own_addr == CTRL_ADDR) & (w_own_data[CS_HI:CS_LO] == '0);
   assign w_ptr_inc  = (r_gnt == OW'(num_req - 1)) ? '0 : r_gnt + OW'(1);

   assign owner        = r_gnt;
   assign req_data_out = (|req_ack) ? dev_data_in : '0;

`ifdef SPIE_ARB_TIMEOUT_EN
   localparam int TW = clog2_min1(timeout_cycles);

   logic [TW-1:0] r_to_cnt;
   logic          w_to_hit;

   assign w_to_hit = (r_to_cnt == TW'(timeout_cycles - 1));

   // Held at zero outside LOCKED, so it is already clear on lock entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_to_cnt <= '0;
      else if (r_state != ST_LOCKED || w_own_stb) r_to_cnt <= '0;
      else                                        r_to_cnt <= r_to_cnt + TW'(1);
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_ptr_nxt    = r_ptr;
      dev_stb      = 1'b0;
      dev_we       = 1'b0;
      dev_addr     = 1'b0;
      dev_data_out = '0;
      req_ack      = '0;
      locked       = 1'b0;
      timeout_evt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_gnt_nxt   = w_pick_idx;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            dev_stb        = w_own_stb;
            dev_we         = w_own_we;
            dev_addr       = w_own_addr;
            dev_data_out   = w_own_data;
            req_ack[r_gnt] = dev_ack;
            if (w_lock_wr) begin
               w_state_nxt = ST_LOCKED;
            end else begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_ptr_inc;
            end
         end
         ST_LOCKED: begin
            dev_stb        = w_own_stb;
            dev_we         = w_own_we;
            dev_addr       = w_own_addr;
            dev_data_out   = w_own_data;
            req_ack[r_gnt] = dev_ack;
            locked         = 1'b1;
            if (w_rel_wr) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_ptr_inc;
            end
`ifdef SPIE_ARB_TIMEOUT_EN
            else if (!w_own_stb && w_to_hit) begin
               w_state_nxt = ST_FORCE;
            end
`endif
         end
`ifdef SPIE_ARB_TIMEOUT_EN
         // Write CS=0 on the owner's behalf to deselect every chip.
         ST_FORCE: begin
            dev_stb     = 1'b1;
            dev_we      = 1'b1;
            dev_addr    = CTRL_ADDR;
            locked      = 1'b1;
            timeout_evt = 1'b1;
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = w_ptr_inc;
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_spie_arb.sv
// ============================================================================
// Module   : tb_spie_arb
// Contents : self-checking bench for spie_arb (directed scenarios + random vs model)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spie_arb;

   localparam int N  = 4;
   localparam int TO = 16;
`ifdef SPIE_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_stb;
   logic [N-1:0]    req_we;
   logic [N-1:0]    req_addr;
   logic [32*N-1:0] req_data_in;
   logic [31:0]     req_data_out;
   logic [N-1:0]    req_ack;
   logic            dev_stb;
   logic            dev_we;
   logic            dev_addr;
   logic [31:0]     dev_data_out;
   logic [31:0]     dev_data_in;
   wire             dev_ack;
   logic            locked;
   logic [1:0]      owner;
   logic            timeout_evt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // The spie device acknowledges combinationally with its strobe.
   assign dev_ack = dev_stb;

   spie_arb #(.num_req(N), .timeout_cycles(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_stb      (req_stb),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_data_in  (req_data_in),
      .req_data_out (req_data_out),
      .req_ack      (req_ack),
      .dev_stb      (dev_stb),
      .dev_we       (dev_we),
      .dev_addr     (dev_addr),
      .dev_data_out (dev_data_out),
      .dev_data_in  (dev_data_in),
      .dev_ack      (dev_ack),
      .locked       (locked),
      .owner        (owner),
      .timeout_evt  (timeout_evt)
   );

   wire [74:0] act = {req_ack, req_data_out, dev_stb, dev_we, dev_addr, dev_data_out,
                      locked, owner, timeout_evt};

   // Reference model: who holds the bus (-1 = arbitration cycle) and whether it is locked.
   int m_holder;
   int m_ptr;
   int m_last;
   int m_idle;
   bit m_locked;
   bit m_force;

   function automatic void model_reset();
      m_holder = -1;
      m_ptr    = 0;
      m_last   = 0;
      m_idle   = 0;
      m_locked = 1'b0;
      m_force  = 1'b0;
   endfunction

   function automatic logic [74:0] expected();
      logic [3:0]  ack = '0;
      logic [31:0] rd  = '0;
      logic        ds  = 1'b0;
      logic        dw  = 1'b0;
      logic        da  = 1'b0;
      logic [31:0] dd  = '0;
      logic        lk  = 1'b0;
      logic        ev  = 1'b0;
      if (m_force) begin
         ds = 1'b1; dw = 1'b1; da = 1'b1; lk = 1'b1; ev = 1'b1;
      end else if (m_holder >= 0) begin
         ds = req_stb[m_holder];
         dw = req_we[m_holder];
         da = req_addr[m_holder];
         dd = req_data_in[32*m_holder +: 32];
         ack[m_holder] = ds;
         rd = ds ? dev_data_in : 32'h0;
         lk = m_locked;
      end
      return {ack, rd, ds, dw, da, dd, lk, 2'(m_last), ev};
   endfunction

   function automatic void model_step();
      int          h;
      logic [31:0] d;
      bit          lockw;
      bit          relw;
      h = m_holder;
      if (m_force) begin
         m_force  = 1'b0;
         m_locked = 1'b0;
         m_holder = -1;
         m_ptr    = (m_last + 1) % N;
      end else if (h < 0) begin
         for (int k = 0; k < N; k++) begin
            if (m_holder < 0 && req_stb[(m_ptr + k) % N]) begin
               m_holder = (m_ptr + k) % N;
               m_last   = m_holder;
            end
         end
      end else begin
         d     = req_data_in[32*h +: 32];
         lockw = req_stb[h] && req_we[h] && req_addr[h] && (d[2:0] != 3'd0);
         relw  = req_stb[h] && req_we[h] && req_addr[h] && (d[2:0] == 3'd0);
         if (!m_locked) begin
            if (lockw) begin
               m_locked = 1'b1;
               m_idle   = 0;
            end else begin
               m_holder = -1;
               m_ptr    = (h + 1) % N;
            end
         end else if (relw) begin
            m_locked = 1'b0;
            m_holder = -1;
            m_ptr    = (h + 1) % N;
         end else if (req_stb[h]) begin
            m_idle = 0;
         end else if (TO_EN && m_idle == TO - 1) begin
            m_force = 1'b1;
         end else begin
            m_idle++;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst) model_step();
   endtask

   task automatic set_in(input logic [N-1:0] s, input logic [N-1:0] w,
                         input logic [N-1:0] a, input logic [32*N-1:0] d);
      req_stb     = s;
      req_we      = w;
      req_addr    = a;
      req_data_in = d;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      model_reset();
      set_in('0, '0, '0, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      set_in('0, '0, '0, '0);
      dev_data_in = 32'hDEAD_BEEF;
      #3;
      n_tests++;
      if (act !== 75'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", act);
      end
      set_in('1, '1, '1, {N{32'h0000_0007}});
      #1;
      n_tests++;
      if (act !== 75'd0) begin
         n_fail++;
         $display("FAIL reset_strobes_ignored: got %h want 0", act);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      set_in('0, '0, '0, '0);
      #3;
      n_tests++;
      if (act !== expected()) begin
         n_fail++;
         $display("FAIL reset_release: got %h want %h", act, expected());
      end
      tick();
   endtask

   task automatic test_status_read();
      dev_data_in = 32'h1;
      set_in(4'b0100, 4'b0000, 4'b0100, '0);
      #3;
      n_tests++;
      if (req_ack !== 4'b0000 || act !== expected()) begin
         n_fail++;
         $display("FAIL status_wait_state: got ack %b vec %h want ack 0000", req_ack, act);
      end
      tick();
      #3;
      n_tests++;
      if (req_ack !== 4'b0100 || req_data_out !== 32'h1 || owner !== 2'd2 || act !== expected()) begin
         n_fail++;
         $display("FAIL status_ack: got ack %b data %h owner %0d want ack 0100 data 1 owner 2",
                  req_ack, req_data_out, owner);
      end
      tick();
      set_in(4'b1001, 4'b0000, 4'b1001, '0);
      #3;
      n_tests++;
      if (req_ack !== 4'b0000 || act !== expected()) begin
         n_fail++;
         $display("FAIL status_back_to_idle: got ack %b want 0000", req_ack);
      end
      tick();
      #3;
      n_tests++;
      if (owner !== 2'd3 || req_ack !== 4'b1000 || act !== expected()) begin
         n_fail++;
         $display("FAIL status_ptr_advance: got owner %0d ack %b want owner 3 ack 1000", owner, req_ack);
      end
      tick();
      set_in('0, '0, '0, '0);
      tick();
   endtask

   task automatic test_lock();
      logic [3:0]  stb_t [7] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
      logic [3:0]  we_t  [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0]  ad_t  [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      logic [31:0] d1_t  [7] = '{32'h1, 32'h1, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [3:0]  ack_t [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
      logic [31:0] dev_t [7] = '{32'h0, 32'h1, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0};
      logic        lk_t  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      dev_data_in = 32'h5A;
      for (int c = 0; c < 7; c++) begin
         set_in(stb_t[c], we_t[c], ad_t[c], {64'h0, d1_t[c], 32'h0});
         #3;
         n_tests++;
         if (req_ack !== ack_t[c] || dev_data_out !== dev_t[c] || locked !== lk_t[c] ||
             act !== expected()) begin
            n_fail++;
            $display("FAIL lock_seq c%0d: got ack %b dev %h lock %b want ack %b dev %h lock %b",
                     c, req_ack, dev_data_out, locked, ack_t[c], dev_t[c], lk_t[c]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_ack;
      reset_pulse();
      dev_data_in = 32'h77;
      set_in('1, '0, '1, '0);
      for (int c = 0; c < 10; c++) begin
         exp_ack = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % N)) : 4'b0000;
         #3;
         n_tests++;
         if (req_ack !== exp_ack || act !== expected()) begin
            n_fail++;
            $display("FAIL rotation c%0d: got ack %b want %b", c, req_ack, exp_ack);
         end
         tick();
      end
      set_in('0, '0, '0, '0);
      tick();
   endtask

   task automatic test_reset_midlock();
      dev_data_in = 32'h3;
      set_in(4'b1000, 4'b1000, 4'b1000, {32'h5, 96'h0});
      tick();
      tick();
      set_in(4'b1000, 4'b1000, 4'b0000, {32'h33, 96'h0});
      #3;
      n_tests++;
      if (locked !== 1'b1 || owner !== 2'd3 || req_ack !== 4'b1000 || act !== expected()) begin
         n_fail++;
         $display("FAIL midlock_held: got lock %b owner %0d ack %b want 1 3 1000", locked, owner, req_ack);
      end
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if (act !== 75'd0) begin
         n_fail++;
         $display("FAIL midlock_async_reset: got %h want 0", act);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_in(4'b1000, 4'b0000, 4'b1000, '0);
      #3;
      n_tests++;
      if (req_ack !== 4'b0000 || locked !== 1'b0 || owner !== 2'd0 || act !== expected()) begin
         n_fail++;
         $display("FAIL midlock_fresh_idle: got ack %b lock %b owner %0d want 0000 0 0", req_ack, locked, owner);
      end
      tick();
      #3;
      n_tests++;
      if (req_ack !== 4'b1000 || locked !== 1'b0 || act !== expected()) begin
         n_fail++;
         $display("FAIL midlock_regrant: got ack %b lock %b want 1000 0", req_ack, locked);
      end
      tick();
      set_in('0, '0, '0, '0);
      tick();
   endtask

   task automatic lock_req0();
      reset_pulse();
      set_in(4'b0001, 4'b0001, 4'b0001, {96'h0, 32'h1});
      tick();
      tick();
      set_in('0, '0, '0, '0);
   endtask

`ifdef SPIE_ARB_TIMEOUT_EN
   task automatic test_timeout();
      lock_req0();
      for (int i = 0; i < TO; i++) begin
         #3;
         n_tests++;
         if (locked !== 1'b1 || timeout_evt !== 1'b0 || act !== expected()) begin
            n_fail++;
            $display("FAIL timeout_wait i%0d: got lock %b evt %b want 1 0", i, locked, timeout_evt);
         end
         tick();
      end
      #3;
      n_tests++;
      if ({dev_stb, dev_we, dev_addr} !== 3'b111 || dev_data_out !== 32'h0 || timeout_evt !== 1'b1 ||
          req_ack !== 4'b0000 || act !== expected()) begin
         n_fail++;
         $display("FAIL timeout_force: got stb/we/addr %b data %h evt %b ack %b want 111 0 1 0000",
                  {dev_stb, dev_we, dev_addr}, dev_data_out, timeout_evt, req_ack);
      end
      tick();
      #3;
      n_tests++;
      if (locked !== 1'b0 || timeout_evt !== 1'b0 || act !== expected()) begin
         n_fail++;
         $display("FAIL timeout_released: got lock %b evt %b want 0 0", locked, timeout_evt);
      end
      tick();
   endtask
`else
   task automatic test_no_timeout();
      lock_req0();
      for (int i = 0; i < 1100; i++) begin
         #3;
         n_tests++;
         if (locked !== 1'b1 || timeout_evt !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_persists i%0d: got lock %b evt %b want 1 0", i, locked, timeout_evt);
         end
         tick();
      end
      set_in(4'b0001, 4'b0001, 4'b0001, '0);
      #3;
      n_tests++;
      if (req_ack !== 4'b0001 || dev_data_out !== 32'h0 || act !== expected()) begin
         n_fail++;
         $display("FAIL owner_release: got ack %b dev %h want 0001 0", req_ack, dev_data_out);
      end
      tick();
      set_in('0, '0, '0, '0);
      tick();
   endtask
`endif

   task automatic test_random();
      int          thresh;
      logic [31:0] d;
      reset_pulse();
      thresh = 4;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) begin
            case ($urandom_range(0, 2))
               0:       thresh = 4;
               1:       thresh = 1;
               default: thresh = 0;
            endcase
         end
         for (int r = 0; r < N; r++) begin
            req_stb[r]  = ($urandom_range(0, 7) < thresh);
            req_we[r]   = $urandom_range(0, 1) == 1;
            req_addr[r] = $urandom_range(0, 1) == 1;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[2:0] = 3'd0;
            req_data_in[32*r +: 32] = d;
         end
         dev_data_in = $urandom;
         #3;
         n_tests++;
         if (act !== expected()) begin
            n_fail++;
            $display("FAIL random c%0d: got %h want %h", c, act, expected());
         end
         tick();
      end
      set_in('0, '0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_status_read();
      test_lock();
      test_back_to_back();
      test_reset_midlock();
`ifdef SPIE_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
